// File: rtl/ui_render_multi.sv
// N-player VGA UI: turn-token arbitration, per-player hop/motion FSMs and a
// 2-stage registered compositor (background, flag, player sprites).
module ui_render_multi #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned GROUND_Y    = 400,
    parameter int unsigned SPRITE_W    = 16,
    parameter int unsigned SPRITE_H    = 24,
    parameter int unsigned START_X     = 32,
    parameter int unsigned STEP_PX     = 2,
    parameter int unsigned HOP_FRAMES  = 4,
    parameter int unsigned JUMP_H      = 6,
    parameter int unsigned FLAG_X      = 600
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [9:0]                     x,
    input  logic [9:0]                     y,
    input  logic [10*NUM_PLAYERS-1:0]      pos_x,
    input  logic [NUM_PLAYERS-1:0]         pos_valid,
    output logic [NUM_PLAYERS-1:0]         turn_done,
    output logic [NUM_PLAYERS-1:0]         busy,
    output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
    output logic [7:0]                     r,
    output logic [7:0]                     g,
    output logic [7:0]                     b
);
    localparam int unsigned AW = $clog2(NUM_PLAYERS);

    localparam logic [9:0] MAX_X     = 10'(H_ACTIVE - SPRITE_W);
    localparam logic [9:0] LAST_X    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LAST_Y    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] X_END     = 10'(H_ACTIVE);
    localparam logic [9:0] Y_END     = 10'(V_ACTIVE);
    localparam logic [9:0] GND       = 10'(GROUND_Y);
    localparam logic [9:0] GRASS_END = 10'(GROUND_Y + 8);
    localparam logic [9:0] SY_REST   = 10'(GROUND_Y - SPRITE_H);
    localparam logic [9:0] SY_HOP    = 10'(GROUND_Y - SPRITE_H - JUMP_H);
    localparam logic [9:0] SPR_W     = 10'(SPRITE_W);
    localparam logic [9:0] SPR_H     = 10'(SPRITE_H);
    localparam logic [9:0] STEP      = 10'(STEP_PX);
    localparam logic [9:0] X_START   = 10'(START_X);
    localparam logic [9:0] POLE_L    = 10'(FLAG_X);
    localparam logic [9:0] POLE_R    = 10'(FLAG_X + 4);
    localparam logic [9:0] PEN_R     = 10'(FLAG_X + 16);
    localparam logic [9:0] FLAG_TOP  = 10'(GROUND_Y - 32);
    localparam logic [9:0] PEN_BOT   = 10'(GROUND_Y - 24);
    localparam logic [7:0] HOP_LAST  = 8'(HOP_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StMove, StDone} state_e;

    function automatic logic [23:0] player_rgb(input int idx);
        case (idx % 4)
            0:       return 24'hFF2020;
            1:       return 24'h2040FF;
            2:       return 24'hFFE020;
            default: return 24'h20C040;
        endcase
    endfunction

    logic                   frame_tick;
    logic [NUM_PLAYERS-1:0] is_done;
    logic [NUM_PLAYERS-1:0] hit_d;
    logic [AW-1:0]          active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (x == LAST_X) && (y == LAST_Y);
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        state_e      state_q;
        logic [9:0]  cur_x_q, target_q;
        logic        hop_q;
        logic [7:0]  hop_cnt_q;
        logic        busy_q, done_q;
        logic [9:0]  req_x, clamp_x, diff, step, nxt_x, sprite_y;
        logic        accept, up;

        always_comb begin
            req_x    = pos_x[10*gi +: 10];
            clamp_x  = (req_x > MAX_X) ? MAX_X : req_x;
            accept   = pos_valid[gi] && (active_player == AW'(gi)) && (state_q == StIdle);
            up       = target_q > cur_x_q;
            diff     = up ? (target_q - cur_x_q) : (cur_x_q - target_q);
            step     = (diff < STEP) ? diff : STEP;
            nxt_x    = up ? (cur_x_q + step) : (cur_x_q - step);
            sprite_y = hop_q ? SY_HOP : SY_REST;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                cur_x_q   <= X_START;
                target_q  <= X_START;
                hop_q     <= 1'b0;
                hop_cnt_q <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            target_q  <= clamp_x;
                            hop_q     <= 1'b0;
                            hop_cnt_q <= '0;
                            if (clamp_x == cur_x_q) begin
                                state_q <= StDone;
                            end else begin
                                state_q <= StMove;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    StMove: begin
                        if (frame_tick) begin
                            cur_x_q <= nxt_x;
                            if (nxt_x == target_q) begin
                                state_q   <= StDone;
                                busy_q    <= 1'b0;
                                hop_q     <= 1'b0;
                                hop_cnt_q <= '0;
                            end else if (hop_cnt_q == HOP_LAST) begin
                                hop_q     <= ~hop_q;
                                hop_cnt_q <= '0;
                            end else begin
                                hop_cnt_q <= hop_cnt_q + 8'd1;
                            end
                        end
                    end
                    StDone: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        hop_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign is_done[gi]   = (state_q == StDone);
        assign busy[gi]      = busy_q;
        assign turn_done[gi] = done_q;
        assign hit_d[gi]     = (x >= cur_x_q) && (x < cur_x_q + SPR_W) &&
                               (y >= sprite_y) && (y < sprite_y + SPR_H);
    end

    // Token passes on the same edge that raises the finishing player's turn_done.
    always_comb begin
        active_d = active_player;
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (is_done[i]) begin
                active_d = (i == int'(NUM_PLAYERS) - 1) ? '0 : AW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_player <= '0;
        end else begin
            active_player <= active_d;
        end
    end

    logic [NUM_PLAYERS-1:0] hit_q;
    logic                   pole_q, pen_q, sky_q, grass_q, blank_q, v1_q;
    logic [23:0]            pix, rgb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= '0;
            pole_q  <= 1'b0;
            pen_q   <= 1'b0;
            sky_q   <= 1'b0;
            grass_q <= 1'b0;
            blank_q <= 1'b1;
            v1_q    <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            pole_q  <= (x >= POLE_L) && (x < POLE_R) && (y >= FLAG_TOP) && (y < GND);
            pen_q   <= (x >= POLE_R) && (x < PEN_R) && (y >= FLAG_TOP) && (y < PEN_BOT);
            sky_q   <= (y < GND);
            grass_q <= (y < GRASS_END);
            blank_q <= (x >= X_END) || (y >= Y_END);
            v1_q    <= 1'b1;
        end
    end

    // Later assignments win, so the loop runs high index to low.
    always_comb begin
        pix = 24'h805020;
        if (sky_q) begin
            pix = 24'h60A0FF;
        end else if (grass_q) begin
            pix = 24'h30B030;
        end
        if (pen_q) pix = 24'hFF0000;
        if (pole_q) pix = 24'hFFFFFF;
        for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
            if (hit_q[i]) pix = player_rgb(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= (v1_q && !blank_q) ? pix : 24'h000000;
        end
    end

    assign r = rgb_q[23:16];
    assign g = rgb_q[15:8];
    assign b = rgb_q[7:0];

endmodule

// File: tb/tb_ui_render_multi.sv
// Directed bench for ui_render_multi: turn token, motion, clamp, compositing, reset.
module tb_ui_render_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [39:0] pos_x = '0;
    logic [3:0]  pos_valid = '0;
    logic [3:0]  turn_done, busy;
    logic [1:0]  active_player;
    logic [7:0]  r, g, b;

    int checks = 0;
    int failures = 0;
    int done_cnt [4] = '{0, 0, 0, 0};

    ui_render_multi dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pos_x(pos_x), .pos_valid(pos_valid),
        .turn_done(turn_done), .busy(busy), .active_player(active_player),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (turn_done[i]) done_cnt[i]++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic probe(input logic [9:0] xx, input logic [9:0] yy, output logic [23:0] rgb);
        @(negedge clk);
        x = xx;
        y = yy;
        @(negedge clk);
        @(negedge clk);
        rgb = {r, g, b};
    endtask

    task automatic tick();
        @(negedge clk);
        x = 10'd639;
        y = 10'd479;
        @(negedge clk);
        x = 10'd0;
        y = 10'd0;
        @(negedge clk);
    endtask

    task automatic request(input int idx, input logic [9:0] val);
        @(negedge clk);
        pos_x[10*idx +: 10] = val;
        pos_valid[idx] = 1'b1;
        @(negedge clk);
        pos_valid = '0;
    endtask

    task automatic test_reset();
        logic [23:0] c;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 4'b0 || turn_done !== 4'b0 || active_player !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b act=%0d, required 0/0/0",
                     busy, turn_done, active_player);
        end
        checks++;
        if ({r, g, b} !== 24'h0) begin
            failures++;
            $display("FAIL reset_rgb: got %h required 000000", {r, g, b});
        end
        rst_n = 1'b1;
        probe(10'd100, 10'd200, c);
        checks++;
        if (c !== 24'h60A0FF) begin failures++; $display("FAIL sky: got %h required 60A0FF", c); end
        probe(10'd700, 10'd10, c);
        checks++;
        if (c !== 24'h000000) begin failures++; $display("FAIL blank: got %h required 000000", c); end
        probe(10'd100, 10'd403, c);
        checks++;
        if (c !== 24'h30B030) begin failures++; $display("FAIL grass: got %h required 30B030", c); end
        probe(10'd100, 10'd450, c);
        checks++;
        if (c !== 24'h805020) begin failures++; $display("FAIL dirt: got %h required 805020", c); end
        probe(10'd601, 10'd380, c);
        checks++;
        if (c !== 24'hFFFFFF) begin failures++; $display("FAIL pole: got %h required FFFFFF", c); end
        probe(10'd610, 10'd370, c);
        checks++;
        if (c !== 24'hFF0000) begin failures++; $display("FAIL pennant: got %h required FF0000", c); end
        probe(10'd36, 10'd390, c);
        checks++;
        if (c !== 24'hFF2020) begin failures++; $display("FAIL overlap_p0: got %h required FF2020", c); end
    endtask

    task automatic test_move_p0();
        logic [23:0] c;
        request(0, 10'd40);
        checks++;
        if (busy !== 4'b0001) begin failures++; $display("FAIL p0_busy: got %b required 0001", busy); end
        tick();
        probe(10'd49, 10'd390, c);
        checks++;
        if (c !== 24'hFF2020) begin failures++; $display("FAIL p0_at34_in: got %h required FF2020", c); end
        probe(10'd50, 10'd390, c);
        checks++;
        if (c !== 24'h60A0FF) begin failures++; $display("FAIL p0_at34_out: got %h required 60A0FF", c); end
        tick();
        tick();
        checks++;
        if (busy !== 4'b0001) begin failures++; $display("FAIL p0_busy3: got %b required 0001", busy); end
        tick();
        checks++;
        if (busy !== 4'b0000 || turn_done !== 4'b0000) begin
            failures++;
            $display("FAIL p0_done_state: busy=%b done=%b required 0000/0000", busy, turn_done);
        end
        @(negedge clk);
        checks++;
        if (turn_done !== 4'b0001 || active_player !== 2'd1) begin
            failures++;
            $display("FAIL p0_turn_done: done=%b act=%0d required 0001/1", turn_done, active_player);
        end
        @(negedge clk);
        checks++;
        if (turn_done !== 4'b0000 || done_cnt[0] != 1) begin
            failures++;
            $display("FAIL p0_single_pulse: done=%b count=%0d required 0000/1", turn_done, done_cnt[0]);
        end
        probe(10'd36, 10'd390, c);
        checks++;
        if (c !== 24'h2040FF) begin failures++; $display("FAIL overlap_p1: got %h required 2040FF", c); end
        probe(10'd55, 10'd390, c);
        checks++;
        if (c !== 24'hFF2020) begin failures++; $display("FAIL p0_at40_edge: got %h required FF2020", c); end
        probe(10'd56, 10'd390, c);
        checks++;
        if (c !== 24'h60A0FF) begin failures++; $display("FAIL p0_at40_out: got %h required 60A0FF", c); end
    endtask

    task automatic test_ignore();
        request(0, 10'd100);
        checks++;
        if (busy !== 4'b0000) begin failures++; $display("FAIL ignore_busy: got %b required 0000", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (active_player !== 2'd1 || done_cnt[0] != 1) begin
            failures++;
            $display("FAIL ignore_token: act=%0d count=%0d required 1/1", active_player, done_cnt[0]);
        end
    endtask

    task automatic test_clamp();
        logic [23:0] c;
        int n;
        request(1, 10'd1000);
        checks++;
        if (busy !== 4'b0010) begin failures++; $display("FAIL p1_busy: got %b required 0010", busy); end
        n = 0;
        while (busy[1] && n < 400) begin
            tick();
            n++;
            if (n == 3) begin
                probe(10'd41, 10'd371, c);
                checks++;
                if (c !== 24'h60A0FF) begin failures++; $display("FAIL hop_low: got %h required 60A0FF", c); end
            end
            if (n == 4) begin
                probe(10'd41, 10'd371, c);
                checks++;
                if (c !== 24'h2040FF) begin failures++; $display("FAIL hop_up: got %h required 2040FF", c); end
            end
            if (n == 10) request(1, 10'd100);
        end
        checks++;
        if (n != 296) begin failures++; $display("FAIL clamp_ticks: got %0d required 296", n); end
        @(negedge clk);
        checks++;
        if (turn_done !== 4'b0010 || active_player !== 2'd2) begin
            failures++;
            $display("FAIL p1_turn_done: done=%b act=%0d required 0010/2", turn_done, active_player);
        end
        probe(10'd630, 10'd390, c);
        checks++;
        if (c !== 24'h2040FF) begin failures++; $display("FAIL clamp_pos: got %h required 2040FF", c); end
        probe(10'd623, 10'd390, c);
        checks++;
        if (c !== 24'h60A0FF) begin failures++; $display("FAIL clamp_left: got %h required 60A0FF", c); end
    endtask

    task automatic test_zero_move();
        request(2, 10'd32);
        checks++;
        if (busy !== 4'b0000 || turn_done !== 4'b0000) begin
            failures++;
            $display("FAIL zero_accept: busy=%b done=%b required 0000/0000", busy, turn_done);
        end
        @(negedge clk);
        checks++;
        if (turn_done !== 4'b0100 || active_player !== 2'd3) begin
            failures++;
            $display("FAIL zero_done: done=%b act=%0d required 0100/3", turn_done, active_player);
        end
        @(negedge clk);
        checks++;
        if (turn_done !== 4'b0000) begin failures++; $display("FAIL zero_pulse: got %b required 0000", turn_done); end
    endtask

    task automatic test_reset_mid_move();
        logic [23:0] c;
        request(3, 10'd100);
        checks++;
        if (busy !== 4'b1000) begin failures++; $display("FAIL p3_busy: got %b required 1000", busy); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b0 || active_player !== 2'd0 || turn_done !== 4'b0 || {r, g, b} !== 24'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b act=%0d done=%b rgb=%h required 0/0/0/000000",
                     busy, active_player, turn_done, {r, g, b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt[3] != 0 || busy !== 4'b0) begin
            failures++;
            $display("FAIL reset_no_done: count=%0d busy=%b required 0/0000", done_cnt[3], busy);
        end
        probe(10'd50, 10'd390, c);
        checks++;
        if (c !== 24'h60A0FF) begin failures++; $display("FAIL reset_pos: got %h required 60A0FF", c); end
        probe(10'd36, 10'd390, c);
        checks++;
        if (c !== 24'hFF2020) begin failures++; $display("FAIL reset_p0: got %h required FF2020", c); end
    endtask

    initial begin
        test_reset();
        test_move_p0();
        test_ignore();
        test_clamp();
        test_zero_move();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
